pcap_word_packer: RTL and testbench

Single-clock 144-to-288-bit packing stage for the pcap replay micro-engine. It sits directly upstream of the write side of the 144→288 async FIFO wrapper and pairs consecutive 144-bit packet words into one 288-bit FIFO word. Odd-length packets are padded with an all-zero word, so every FIFO word belongs to exactly one packet. It applies FIFO backpressure to the upstream word source and keeps pair and pad statistics.

---
 rtl/pcap_word_packer.sv | 105 ++++++++++
 tb/tb_pcap_word_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcap_word_packer.sv
// pcap_word_packer: pairs 144-bit packet words into 288-bit FIFO words,
// padding odd packet tails with a zero upper half.
module pcap_word_packer #(
  parameter int IN_WIDTH  = 144,
  parameter int OUT_WIDTH = 288,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [OUT_WIDTH-1:0] fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  input  logic                 fifo_prog_full,
  output logic [CNT_WIDTH-1:0] pair_cnt,
  output logic [CNT_WIDTH-1:0] pad_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  low_q, low_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 out_valid_q, out_valid_d;
  logic                 pad_pending_q, pad_pending_d;
  logic [CNT_WIDTH-1:0] pair_q, pad_q;
  logic                 accept;
  logic                 wr;

  // prog_full only blocks new pairs; a held low half may always finish
  assign s_ready = !rst
                 && !(out_valid_q && fifo_full)
                 && !(state_q == EMPTY && fifo_prog_full);

  assign accept = s_valid && s_ready;
  assign wr     = out_valid_q && !fifo_full && !rst;

  assign fifo_wr_en = wr;
  assign fifo_din   = dout_q;
  assign pair_cnt   = pair_q;
  assign pad_cnt    = pad_q;

  always_comb begin
    state_d       = state_q;
    low_d         = low_q;
    dout_d        = dout_q;
    out_valid_d   = out_valid_q && !wr;
    pad_pending_d = pad_pending_q && !wr;
    if (accept) begin
      unique case (state_q)
        EMPTY: begin
          if (s_last) begin
            out_valid_d   = 1'b1;
            dout_d        = {{IN_WIDTH{1'b0}}, s_data};
            pad_pending_d = 1'b1;
          end else begin
            low_d   = s_data;
            state_d = HALF;
          end
        end
        HALF: begin
          out_valid_d   = 1'b1;
          dout_d        = {s_data, low_q};
          pad_pending_d = 1'b0;
          state_d       = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      low_q         <= '0;
      dout_q        <= '0;
      out_valid_q   <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      dout_q        <= dout_d;
      out_valid_q   <= out_valid_d;
      pad_pending_q <= pad_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q <= '0;
      pad_q  <= '0;
    end else if (wr) begin
      pair_q <= pair_q + CNT_WIDTH'(1);
      if (pad_pending_q)
        pad_q <= pad_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pcap_word_packer.sv
// tb_pcap_word_packer: table-driven packets plus directed corner cases,
// with a queue scoreboard of expected FIFO words.
module tb_pcap_word_packer;

  localparam int IW = 144;
  localparam int OW = 288;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [IW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [OW-1:0] fifo_din;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          fifo_prog_full;
  logic [CW-1:0] pair_cnt;
  logic [CW-1:0] pad_cnt;

  pcap_word_packer #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .fifo_din      (fifo_din),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .fifo_prog_full(fifo_prog_full),
    .pair_cnt      (pair_cnt),
    .pad_cnt       (pad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          pad;
  } exp_t;

  typedef struct {
    int len;
    int pairs;
    int pads;
  } vec_t;

  exp_t          q[$];
  bit            m_half;
  logic [IW-1:0] m_low;
  logic [CW-1:0] m_pair;
  logic [CW-1:0] m_pad;
  bit            acc_last;
  bit            rand_bp;
  int            nerr;
  int            nchk;

  task automatic chk(input string name, input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model, evaluated mid-cycle
  task automatic mon();
    bit   er;
    bit   ew;
    exp_t e;
    acc_last = 1'b0;
    if (rst) begin
      chk("s_ready_rst", OW'(s_ready), OW'(0));
      chk("wr_en_rst", OW'(fifo_wr_en), OW'(0));
      q.delete();
      m_half = 1'b0;
      m_pair = '0;
      m_pad  = '0;
      return;
    end
    ew = (q.size() > 0) && !fifo_full;
    er = !((q.size() > 0) && fifo_full) && !(!m_half && fifo_prog_full);
    chk("s_ready", OW'(s_ready), OW'(er));
    chk("wr_en", OW'(fifo_wr_en), OW'(ew));
    chk("pair_cnt", OW'(pair_cnt), OW'(m_pair));
    chk("pad_cnt", OW'(pad_cnt), OW'(m_pad));
    if (ew) begin
      e = q.pop_front();
      chk("fifo_din", fifo_din, e.d);
      m_pair = m_pair + 1'b1;
      if (e.pad) m_pad = m_pad + 1'b1;
    end
    if (s_valid && er) begin
      acc_last = 1'b1;
      if (m_half) begin
        q.push_back('{d: {s_data, m_low}, pad: 1'b0});
        m_half = 1'b0;
      end else if (s_last) begin
        q.push_back('{d: {{IW{1'b0}}, s_data}, pad: 1'b1});
      end else begin
        m_low  = s_data;
        m_half = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rand_bp) begin
      fifo_full      = ($urandom_range(0, 2) == 0);
      fifo_prog_full = ($urandom_range(0, 3) == 0);
    end
  endtask

  function automatic logic [IW-1:0] mkword();
    return {16'hffff, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_word(input logic [IW-1:0] d, input logic last);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 300);
    if (!acc_last) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++)
      send_word(mkword(), (i == len - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || m_half) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      nchk++;
      nerr++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    tick();
    tick();
  endtask

  vec_t          tbl[6];
  logic [IW-1:0] w0, w1, w2;
  logic [OW-1:0] held;
  int            cum_p;
  int            cum_d;
  int            len;

  initial begin
    tbl[0] = '{len: 4, pairs: 2, pads: 0};
    tbl[1] = '{len: 3, pairs: 2, pads: 1};
    tbl[2] = '{len: 1, pairs: 1, pads: 1};
    tbl[3] = '{len: 2, pairs: 1, pads: 0};
    tbl[4] = '{len: 5, pairs: 3, pads: 1};
    tbl[5] = '{len: 6, pairs: 3, pads: 0};

    nerr = 0;
    nchk = 0;
    rand_bp = 1'b0;
    m_half = 1'b0;
    m_low = '0;
    m_pair = '0;
    m_pad = '0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    fifo_full = 1'b0;
    fifo_prog_full = 1'b0;

    repeat (3) tick();
    chk("rst_s_ready", OW'(s_ready), OW'(0));
    chk("rst_fifo_din", fifo_din, OW'(0));
    chk("rst_pair_cnt", OW'(pair_cnt), OW'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", OW'(s_ready), OW'(1));
    chk("post_rst_wr_en", OW'(fifo_wr_en), OW'(0));

    cum_p = 0;
    cum_d = 0;
    for (int i = 0; i < 6; i++) begin
      send_pkt(tbl[i].len);
      drain();
      cum_p += tbl[i].pairs;
      cum_d += tbl[i].pads;
      chk("tbl_pair_cnt", OW'(pair_cnt), OW'(cum_p % 16));
      chk("tbl_pad_cnt", OW'(pad_cnt), OW'(cum_d % 16));
    end

    fifo_full = 1'b1;
    w0 = mkword();
    w1 = mkword();
    send_word(w0, 1'b0);
    send_word(w1, 1'b1);
    held = {w1, w0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_din_hold", fifo_din, held);
      chk("full_wr_en", OW'(fifo_wr_en), OW'(0));
      chk("full_s_ready", OW'(s_ready), OW'(0));
    end
    fifo_full = 1'b0;
    #1;
    chk("release_wr_en", OW'(fifo_wr_en), OW'(1));
    drain();

    w0 = mkword();
    w1 = mkword();
    w2 = mkword();
    send_word(w0, 1'b0);
    fifo_prog_full = 1'b1;
    send_word(w1, 1'b0);
    s_valid = 1'b1;
    s_data  = w2;
    s_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pfull_no_accept", OW'(acc_last), OW'(0));
    end
    chk("pfull_s_ready", OW'(s_ready), OW'(0));
    fifo_prog_full = 1'b0;
    #1;
    chk("pfull_resume", OW'(s_ready), OW'(1));
    send_word(w2, 1'b0);
    send_word(mkword(), 1'b1);
    drain();

    send_word(mkword(), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_pair_cnt", OW'(pair_cnt), OW'(0));
    chk("midrst_pad_cnt", OW'(pad_cnt), OW'(0));
    send_pkt(2);
    drain();
    chk("midrst_pair_after", OW'(pair_cnt), OW'(1));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) send_pkt(1);
    drain();
    chk("wrap_pair_cnt", OW'(pair_cnt), OW'(1));
    chk("wrap_pad_cnt", OW'(pad_cnt), OW'(1));

    cum_p = 1;
    rand_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      len = $urandom_range(1, 6);
      send_pkt(len);
      cum_p += (len + 1) / 2;
    end
    rand_bp = 1'b0;
    fifo_full = 1'b0;
    fifo_prog_full = 1'b0;
    drain();
    chk("rand_pair_cnt", OW'(pair_cnt), OW'(cum_p % 16));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
